id_exe_stage_reg: RTL

ID_EXE_STAGE_REG -- requirements
Module: id_exe_stage_reg

---
 rtl/id_exe_stage_reg.sv | 102 ++++++++++
 1 files changed

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register: flush > freeze > capture priority, with a valid bit for the EXE slot.
// Optional statistics counters (stall_cycles, flush_count) are compiled in with ID_EXE_STATS_EN.
module id_exe_stage_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic        flush,
  input  logic [3:0]  id_alu_cmd,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_wb_en,
  input  logic        id_is_imm,
  input  logic [1:0]  id_branch_type,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_val1,
  input  logic [31:0] id_val2,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_src1,
  input  logic [4:0]  id_src2,
  input  logic [4:0]  id_dest,
  output logic [3:0]  exe_alu_cmd,
  output logic        exe_mem_read,
  output logic        exe_mem_write,
  output logic        exe_wb_en,
  output logic        exe_is_imm,
  output logic [1:0]  exe_branch_type,
  output logic [31:0] exe_pc,
  output logic [31:0] exe_val1,
  output logic [31:0] exe_val2,
  output logic [31:0] exe_imm,
  output logic [4:0]  exe_src1,
  output logic [4:0]  exe_src2,
  output logic [4:0]  exe_dest,
  output logic        exe_valid,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  localparam int unsigned CNT_W = 16;

  // Flush and reset both leave a clean bubble; freeze simply skips the load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      if (!rst_n || flush) begin
        exe_alu_cmd     <= 4'b0000;
        exe_mem_read    <= 1'b0;
        exe_mem_write   <= 1'b0;
        exe_wb_en       <= 1'b0;
        exe_is_imm      <= 1'b0;
        exe_branch_type <= 2'b00;
        exe_pc          <= 32'd0;
        exe_val1        <= 32'd0;
        exe_val2        <= 32'd0;
        exe_imm         <= 32'd0;
        exe_src1        <= 5'd0;
        exe_src2        <= 5'd0;
        exe_dest        <= 5'd0;
        exe_valid       <= 1'b0;
      end
    end else if (!freeze) begin
      exe_alu_cmd     <= id_alu_cmd;
      exe_mem_read    <= id_mem_read;
      exe_mem_write   <= id_mem_write;
      exe_wb_en       <= id_wb_en;
      exe_is_imm      <= id_is_imm;
      exe_branch_type <= id_branch_type;
      exe_pc          <= id_pc;
      exe_val1        <= id_val1;
      exe_val2        <= id_val2;
      exe_imm         <= id_imm;
      exe_src1        <= id_src1;
      exe_src2        <= id_src2;
      exe_dest        <= id_dest;
      exe_valid       <= 1'b1;
    end
  end

`ifdef ID_EXE_STATS_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Saturating event counters; a flushed edge is not a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= CNT_W'(0);
      flush_q <= CNT_W'(0);
    end else begin
      if (freeze && !flush && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + CNT_W'(1);
      if (flush && (flush_q != {CNT_W{1'b1}}))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = CNT_W'(0);
  assign flush_count  = CNT_W'(0);
`endif

endmodule
